// File: rtl/player_bullet.sv
// Player projectile: launch, climb, box collision and one-cycle hit strobe.
// Optional refire lockout: define PLAYER_BULLET_COOLDOWN_EN.
module player_bullet #(
   parameter logic [11:0] color_p    = 12'hFF0,
   parameter logic [9:0]  width_p    = 10'd2,
   parameter logic [9:0]  height_p   = 10'd8,
   parameter logic [9:0]  step_p     = 10'd4,
   parameter logic [9:0]  x_offset_p = 10'd19,
   parameter logic [5:0]  cooldown_p = 6'd30
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       frame_i,
   input  logic       fire_i,
   input  logic [9:0] player_left_i,
   input  logic [9:0] player_top_i,
   input  logic [9:0] enemy_left_i,
   input  logic [9:0] enemy_right_i,
   input  logic [9:0] enemy_top_i,
   input  logic [9:0] enemy_bot_i,
   input  logic       enemy_dead_i,
   output logic       hit_o,
   output logic       active_o,
   output logic [9:0] left_pos_o,
   output logic [9:0] right_pos_o,
   output logic [9:0] top_pos_o,
   output logic [9:0] bot_pos_o,
   output logic [3:0] bullet_red_o,
   output logic [3:0] bullet_green_o,
   output logic [3:0] bullet_blue_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      FLYING = 3'b010,
      HIT    = 3'b100
   } state_e;

   state_e     state_q, state_d;
   logic [9:0] left_q, left_d;
   logic [9:0] top_q, top_d;
   logic       overlap;
   logic       fire_ok;

   assign left_pos_o  = left_q;
   assign top_pos_o   = top_q;
   assign right_pos_o = left_q + width_p - 10'd1;
   assign bot_pos_o   = top_q + height_p - 10'd1;
   assign active_o    = (state_q == FLYING);
   assign hit_o       = (state_q == HIT);

   assign bullet_red_o   = color_p[11:8];
   assign bullet_green_o = color_p[7:4];
   assign bullet_blue_o  = color_p[3:0];

   assign overlap = (left_q <= enemy_right_i) &
                    (right_pos_o >= enemy_left_i) &
                    (top_q <= enemy_bot_i) &
                    (bot_pos_o >= enemy_top_i) &
                    ~enemy_dead_i;

`ifdef PLAYER_BULLET_COOLDOWN_EN
   logic [5:0] cd_q;

   assign fire_ok = (cd_q == 6'd0);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cd_q <= 6'd0;
      end else if ((state_q == FLYING || state_q == HIT) &&
                   state_d == IDLE) begin
         cd_q <= cooldown_p;
      end else if (frame_i && cd_q != 6'd0) begin
         cd_q <= cd_q - 6'd1;
      end
   end
`else
   assign fire_ok = 1'b1;
`endif

   always_comb begin
      state_d = IDLE;
      left_d  = left_q;
      top_d   = top_q;
      case (state_q)
         IDLE: begin
            if (fire_i && fire_ok) begin
               state_d = FLYING;
               left_d  = player_left_i + x_offset_p;
               top_d   = player_top_i - height_p;
            end
         end
         FLYING: begin
            // collision wins over the frame step
            if (overlap) begin
               state_d = HIT;
            end else if (frame_i && top_q < step_p) begin
               state_d = IDLE;
            end else begin
               state_d = FLYING;
               if (frame_i) top_d = top_q - step_p;
            end
         end
         HIT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         left_q  <= 10'd0;
         top_q   <= 10'd0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         top_q   <= top_d;
      end
   end

endmodule

// File: tb/tb_player_bullet.sv
// Directed vector bench for player_bullet (default build, no cooldown).
module tb_player_bullet;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic       frame_i, fire_i, enemy_dead_i;
   logic [9:0] player_left_i, player_top_i;
   logic [9:0] enemy_left_i, enemy_right_i;
   logic [9:0] enemy_top_i, enemy_bot_i;
   logic       hit_o, active_o;
   logic [9:0] left_pos_o, right_pos_o;
   logic [9:0] top_pos_o, bot_pos_o;
   logic [3:0] bullet_red_o, bullet_green_o, bullet_blue_o;

   int passed = 0;
   int total  = 0;
   int hit_cnt = 0;
   int consec  = 0;
   logic hit_prev = 1'b0;

   always #5 clk_i = ~clk_i;

   player_bullet dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .frame_i(frame_i), .fire_i(fire_i),
      .player_left_i(player_left_i),
      .player_top_i(player_top_i),
      .enemy_left_i(enemy_left_i),
      .enemy_right_i(enemy_right_i),
      .enemy_top_i(enemy_top_i),
      .enemy_bot_i(enemy_bot_i),
      .enemy_dead_i(enemy_dead_i),
      .hit_o(hit_o), .active_o(active_o),
      .left_pos_o(left_pos_o),
      .right_pos_o(right_pos_o),
      .top_pos_o(top_pos_o),
      .bot_pos_o(bot_pos_o),
      .bullet_red_o(bullet_red_o),
      .bullet_green_o(bullet_green_o),
      .bullet_blue_o(bullet_blue_o)
   );

   always @(negedge clk_i) begin
      if (hit_o) hit_cnt++;
      if (hit_o && hit_prev) consec++;
      hit_prev <= hit_o;
   end

   typedef struct {
      int         n;
      logic       fire, frame;
      logic [9:0] pl, pt;
      logic       box, dead;
      logic       act, hit;
      logic [9:0] left, top;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(int n, logic fi, logic fr,
                               logic [9:0] pl, logic [9:0] pt,
                               logic bx, logic dd, logic ac,
                               logic ht, logic [9:0] l,
                               logic [9:0] t);
      vec_t v;
      v.n = n; v.fire = fi; v.frame = fr;
      v.pl = pl; v.pt = pt; v.box = bx; v.dead = dd;
      v.act = ac; v.hit = ht; v.left = l; v.top = t;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic set_enemy(input logic bx);
      if (bx) begin
         enemy_left_i = 10'd310; enemy_right_i = 10'd350;
         enemy_top_i  = 10'd380; enemy_bot_i   = 10'd390;
      end else begin
         enemy_left_i = 10'd600; enemy_right_i = 10'd610;
         enemy_top_i  = 10'd0;   enemy_bot_i   = 10'd10;
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      tbl[0]  = mk(1,  1, 0, 300, 440, 0, 0, 1, 0, 319, 432);
      tbl[1]  = mk(10, 0, 1, 300, 440, 0, 0, 1, 0, 319, 392);
      tbl[2]  = mk(1,  1, 0, 100, 200, 0, 0, 1, 0, 319, 392);
      tbl[3]  = mk(1,  0, 0, 300, 440, 1, 0, 1, 0, 319, 392);
      tbl[4]  = mk(1,  0, 1, 300, 440, 1, 0, 1, 0, 319, 388);
      tbl[5]  = mk(1,  0, 1, 300, 440, 1, 0, 0, 1, 319, 388);
      tbl[6]  = mk(1,  0, 0, 300, 440, 1, 0, 0, 0, 319, 388);
      tbl[7]  = mk(1,  1, 0, 300, 440, 1, 0, 1, 0, 319, 432);
      tbl[8]  = mk(11, 0, 1, 300, 440, 1, 1, 1, 0, 319, 388);
      tbl[9]  = mk(5,  0, 1, 300, 440, 1, 1, 1, 0, 319, 368);
      tbl[10] = mk(1,  0, 1, 300, 440, 1, 0, 1, 0, 319, 364);
      tbl[11] = mk(91, 0, 1, 300, 440, 0, 0, 1, 0, 319, 0);
      tbl[12] = mk(1,  0, 1, 300, 440, 0, 0, 0, 0, 319, 0);
      tbl[13] = mk(1,  1, 0, 0,   10,  0, 0, 1, 0, 19,  2);
      tbl[14] = mk(1,  0, 1, 0,   10,  0, 0, 0, 0, 19,  2);
      tbl[15] = mk(1,  1, 0, 300, 440, 0, 0, 1, 0, 319, 432);

      reset_ni = 1'b0; frame_i = 1'b0; fire_i = 1'b0;
      enemy_dead_i = 1'b0;
      player_left_i = 10'd0; player_top_i = 10'd0;
      set_enemy(1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_active", active_o, 0);
      chk("rst_hit", hit_o, 0);
      chk("rst_left", left_pos_o, 0);
      chk("rst_top", top_pos_o, 0);
      chk("rst_right", right_pos_o, 1);
      chk("rst_bot", bot_pos_o, 7);
      chk("red", bullet_red_o, 4'hF);
      chk("green", bullet_green_o, 4'hF);
      chk("blue", bullet_blue_o, 4'h0);
      @(negedge clk_i);
      reset_ni = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         fire_i = tbl[i].fire;
         frame_i = tbl[i].frame;
         player_left_i = tbl[i].pl;
         player_top_i = tbl[i].pt;
         set_enemy(tbl[i].box);
         enemy_dead_i = tbl[i].dead;
         repeat (tbl[i].n) @(posedge clk_i);
         #1;
         chk($sformatf("r%0d_active", i), active_o, tbl[i].act);
         chk($sformatf("r%0d_hit", i), hit_o, tbl[i].hit);
         chk($sformatf("r%0d_left", i), left_pos_o, tbl[i].left);
         chk($sformatf("r%0d_top", i), top_pos_o, tbl[i].top);
         chk($sformatf("r%0d_right", i), right_pos_o,
             tbl[i].left + 10'd1);
         chk($sformatf("r%0d_bot", i), bot_pos_o,
             tbl[i].top + 10'd7);
      end
      chk("hits_after_table", hit_cnt, 1);

      // async reset while the bullet is in flight
      @(negedge clk_i);
      fire_i = 1'b0; frame_i = 1'b0;
      reset_ni = 1'b0;
      #1;
      chk("arst_active", active_o, 0);
      chk("arst_hit", hit_o, 0);
      chk("arst_top", top_pos_o, 0);
      chk("arst_left", left_pos_o, 0);
      @(negedge clk_i);
      reset_ni = 1'b1;
      tick();
      chk("arst_idle", active_o, 0);

      // hit with fire held: single pulse, then auto-repeat launch
      @(negedge clk_i);
      fire_i = 1'b1; frame_i = 1'b0;
      player_left_i = 10'd300; player_top_i = 10'd400;
      set_enemy(1'b1);
      tick();
      chk("ar_launch_top", top_pos_o, 392);
      chk("ar_launch_act", active_o, 1);
      @(negedge clk_i);
      frame_i = 1'b1;
      tick();
      chk("ar_step_top", top_pos_o, 388);
      chk("ar_step_act", active_o, 1);
      tick();
      chk("ar_hit", hit_o, 1);
      chk("ar_hit_act", active_o, 0);
      chk("ar_hit_top", top_pos_o, 388);
      @(negedge clk_i);
      frame_i = 1'b0;
      tick();
      chk("ar_idle_hit", hit_o, 0);
      chk("ar_idle_act", active_o, 0);
      tick();
      chk("ar_relaunch_act", active_o, 1);
      chk("ar_relaunch_top", top_pos_o, 392);
      @(negedge clk_i);
      fire_i = 1'b0;
      set_enemy(1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      chk("hits_total", hit_cnt, 2);
      chk("hit_consecutive", consec, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
